// File: rtl/reservoir_pkg.sv
// reservoir_pkg
// Shared constants for the reservoir level model: FSM state encoding,
// default valve rates, sensor thresholds and the level saturation helper.
package reservoir_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_FILL  = 2'b01;
    localparam state_t ST_DRAIN = 2'b10;
    localparam state_t ST_FAULT = 2'b11;

    localparam int DEF_TICK_DIV   = 4;
    localparam int DEF_CAPACITY   = 200;
    localparam int DEF_FILL_RATE  = 4;
    localparam int DEF_SPR_RATE   = 3;
    localparam int DEF_DRIP_RATE  = 1;
    localparam int DEF_CLEAN_RATE = 8;
    localparam int DEF_L_TH       = 20;
    localparam int DEF_M_TH       = 100;
    localparam int DEF_H_TH       = 180;
    localparam int DEF_OVF_TICKS  = 3;

    // Clamp a signed net level into [0, cap]; never wraps.
    function automatic logic [7:0] clamp_level(input logic signed [9:0] net,
                                               input logic [7:0] cap);
        logic signed [9:0] cap_s;
        cap_s = $signed({2'b00, cap});
        if (net < 10'sd0)
            return 8'd0;
        else if (net > cap_s)
            return cap;
        else
            return 8'(net);
    endfunction

endpackage

// File: rtl/reservoir_model_tick_gen.sv
// tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV clocks. The counter
// clears on reset, so the first tick lands TICK_DIV edges after release.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high
//   tick   - one-cycle pulse, high while the count sits at TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/reservoir_model.sv
// reservoir_model
// Tick-based water reservoir: integrates valve flows into a saturating level,
// drives registered level sensors and a small flow/fault FSM.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   fill_en, Ag, drip_en  - inlet, sprinkler and drip valves
//   Ve                    - cleaning drain valve
//   clr_err               - fault clear request (honoured only in FAULT)
//   level                 - current level in units
//   H, M, L               - level sensors, one cycle behind level
//   E                     - fault flag
//   working               - some valve active and not faulted
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | no net flow (no valves, or inflow == outflow)
// ST_FILL  | inflow exceeds outflow
// ST_DRAIN | outflow exceeds inflow
// ST_FAULT | overflow/dry persisted; level frozen until cleared
module reservoir_model
    import reservoir_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int CAPACITY   = DEF_CAPACITY,
    parameter int FILL_RATE  = DEF_FILL_RATE,
    parameter int SPR_RATE   = DEF_SPR_RATE,
    parameter int DRIP_RATE  = DEF_DRIP_RATE,
    parameter int CLEAN_RATE = DEF_CLEAN_RATE,
    parameter int L_TH       = DEF_L_TH,
    parameter int M_TH       = DEF_M_TH,
    parameter int H_TH       = DEF_H_TH,
    parameter int OVF_TICKS  = DEF_OVF_TICKS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fill_en,
    input  logic       Ag,
    input  logic       drip_en,
    input  logic       Ve,
    input  logic       clr_err,
    output logic [7:0] level,
    output logic       H,
    output logic       M,
    output logic       L,
    output logic       E,
    output logic       working
);

    localparam int FW = $clog2(OVF_TICKS + 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(OVF_TICKS);
    localparam logic [7:0]    CAP_LVL  = 8'(CAPACITY);

    logic               tick;
    state_t             state, state_next;
    logic [FW-1:0]      fault_cnt;
    logic signed [9:0]  inflow, outflow, net;
    logic [7:0]         level_next;
    logic               valves_any, ovf_cond, dry_cond;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        inflow     = fill_en ? 10'(FILL_RATE) : 10'sd0;
        outflow    = (Ag      ? 10'(SPR_RATE)   : 10'sd0)
                   + (drip_en ? 10'(DRIP_RATE)  : 10'sd0)
                   + (Ve      ? 10'(CLEAN_RATE) : 10'sd0);
        net        = $signed({2'b00, level}) + inflow - outflow;
        level_next = clamp_level(net, CAP_LVL);
        valves_any = fill_en | Ag | drip_en | Ve;
        ovf_cond   = fill_en && (level == CAP_LVL);
        dry_cond   = (outflow != 10'sd0) && (level == 8'd0);
    end

    always_comb begin
        state_next = state;
        if (state == ST_FAULT) begin
            if (clr_err && !valves_any)
                state_next = ST_IDLE;
        end else if (fault_cnt == FCNT_MAX) begin
            state_next = ST_FAULT;
        end else if (inflow > outflow) begin
            state_next = ST_FILL;
        end else if (outflow > inflow) begin
            state_next = ST_DRAIN;
        end else begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            level     <= 8'd0;
            fault_cnt <= '0;
            H         <= 1'b0;
            M         <= 1'b0;
            L         <= 1'b1;
            working   <= 1'b0;
        end else begin
            state   <= state_next;
            H       <= (level >= 8'(H_TH));
            M       <= (level >= 8'(M_TH));
            L       <= (level <= 8'(L_TH));
            working <= valves_any && (state_next != ST_FAULT);
            if (state == ST_FAULT) begin
                // Leaving FAULT must not re-enter it from a stale count.
                if (state_next == ST_IDLE)
                    fault_cnt <= '0;
            end else if (tick && state_next != ST_FAULT) begin
                level <= level_next;
                if (ovf_cond || dry_cond) begin
                    if (fault_cnt != FCNT_MAX)
                        fault_cnt <= fault_cnt + 1'b1;
                end else begin
                    fault_cnt <= '0;
                end
            end
        end
    end

    assign E = (state == ST_FAULT);

endmodule

// File: tb/tb_reservoir_model.sv
module tb_reservoir_model;

    localparam int TD = 4, CAP = 200, FR = 4, SR = 3, DR = 1, CR = 8;
    localparam int LT = 20, MT = 100, HT = 180, OVF = 3;
    localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_DRAIN = 2'd2;

    logic       clock = 1'b0;
    logic       reset, fill_en, Ag, drip_en, Ve, clr_err;
    logic [7:0] level;
    logic       H, M, L, E, working;

    always #5 clock = ~clock;

    reservoir_model #(
        .TICK_DIV(TD), .CAPACITY(CAP), .FILL_RATE(FR), .SPR_RATE(SR),
        .DRIP_RATE(DR), .CLEAN_RATE(CR), .L_TH(LT), .M_TH(MT), .H_TH(HT),
        .OVF_TICKS(OVF)
    ) dut (
        .clock(clock), .reset(reset), .fill_en(fill_en), .Ag(Ag),
        .drip_en(drip_en), .Ve(Ve), .clr_err(clr_err), .level(level),
        .H(H), .M(M), .L(L), .E(E), .working(working)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: level in plain integers, cycles counted since reset,
    // consecutive bad ticks counted as a run length.
    int m_level, m_run, m_cyc;
    bit m_fault, m_H, m_M, m_L, m_work;

    typedef struct {
        bit rst, f, a, d, v, c;
        int cyc;
        int lvl;
        bit e, h, l, w;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit f, bit a, bit d, bit v, bit c,
                                int cyc, int lvl, bit e, bit h, bit l, bit w);
        vec_t r;
        r.rst = rst; r.f = f; r.a = a; r.d = d; r.v = v; r.c = c;
        r.cyc = cyc; r.lvl = lvl; r.e = e; r.h = h; r.l = l; r.w = w;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int in_u, out_u;
        bit any, tick;
        if (reset) begin
            m_level = 0; m_run = 0; m_cyc = 0; m_fault = 0;
            m_H = 0; m_M = 0; m_L = 1; m_work = 0;
            return;
        end
        m_cyc++;
        tick  = (m_cyc % TD) == 0;
        in_u  = fill_en ? FR : 0;
        out_u = SR * int'(Ag) + DR * int'(drip_en) + CR * int'(Ve);
        any   = fill_en | Ag | drip_en | Ve;
        m_H = (m_level >= HT);
        m_M = (m_level >= MT);
        m_L = (m_level <= LT);
        if (m_fault) begin
            if (clr_err && !any) begin
                m_fault = 0;
                m_run   = 0;
            end
        end else if (m_run >= OVF) begin
            m_fault = 1;
        end else if (tick) begin
            if ((fill_en && m_level == CAP) || (out_u > 0 && m_level == 0))
                m_run++;
            else
                m_run = 0;
            m_level = m_level + in_u - out_u;
            if (m_level < 0) m_level = 0;
            if (m_level > CAP) m_level = CAP;
        end
        m_work = any && !m_fault;
    endtask

    task automatic set_in(input bit rst, input bit f, input bit a, input bit d,
                          input bit v, input bit c);
        reset = rst; fill_en = f; Ag = a; drip_en = d; Ve = v; clr_err = c;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("model_level", int'(level), m_level);
        check("model_H", int'(H), int'(m_H));
        check("model_M", int'(M), int'(m_M));
        check("model_L", int'(L), int'(m_L));
        check("model_E", int'(E), int'(m_fault));
        check("model_working", int'(working), int'(m_work));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0);

        //              rst f a d v c  cyc lvl  e h l w
        tbl.push_back(mk(1, 0,0,0,0,0,   2,   0, 0,0,1,0));
        tbl.push_back(mk(0, 1,0,0,0,0, 100, 100, 0,0,0,1));
        tbl.push_back(mk(0, 1,1,0,0,0,  20, 105, 0,0,0,1));
        tbl.push_back(mk(0, 1,0,1,1,0,  20,  80, 0,0,0,1));
        tbl.push_back(mk(0, 1,0,0,0,0, 100, 180, 0,0,0,1));
        tbl.push_back(mk(0, 1,0,0,0,0,   1, 180, 0,1,0,1));
        tbl.push_back(mk(0, 1,0,0,0,0,  19, 200, 0,1,0,1));
        tbl.push_back(mk(0, 1,0,0,0,0,   8, 200, 0,1,0,1));
        tbl.push_back(mk(0, 0,0,0,0,0,   4, 200, 0,1,0,0));
        tbl.push_back(mk(0, 1,0,0,0,0,  12, 200, 0,1,0,1));
        tbl.push_back(mk(0, 1,0,0,0,0,   1, 200, 1,1,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1,   8, 200, 1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,   1, 200, 0,1,0,0));
        tbl.push_back(mk(1, 0,0,0,0,0,   1,   0, 0,0,1,0));
        tbl.push_back(mk(0, 1,0,0,0,0,   4,   4, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,1,0,0,   8,   2, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,0,1,0,   4,   0, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,0,1,0,   8,   0, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,0,0,0,   4,   0, 0,0,1,0));
        tbl.push_back(mk(0, 0,0,0,1,0,  12,   0, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,0,1,0,   1,   0, 1,0,1,0));
        tbl.push_back(mk(0, 0,0,0,1,1,   4,   0, 1,0,1,0));
        tbl.push_back(mk(0, 0,0,0,0,1,   1,   0, 0,0,1,0));

        foreach (tbl[k]) begin
            set_in(tbl[k].rst, tbl[k].f, tbl[k].a, tbl[k].d, tbl[k].v, tbl[k].c);
            run(tbl[k].cyc);
            check($sformatf("vec%0d_level", k), int'(level), tbl[k].lvl);
            check($sformatf("vec%0d_E", k), int'(E), int'(tbl[k].e));
            check($sformatf("vec%0d_H", k), int'(H), int'(tbl[k].h));
            check($sformatf("vec%0d_L", k), int'(L), int'(tbl[k].l));
            check($sformatf("vec%0d_working", k), int'(working), int'(tbl[k].w));
        end

        // First tick lands TICK_DIV edges after reset release.
        set_in(1, 0, 0, 0, 0, 0);
        run(1);
        set_in(0, 1, 0, 0, 0, 0);
        run(TD - 1);
        check("first_tick_early", int'(level), 0);
        run(1);
        check("first_tick", int'(level), FR);
        check("state_fill", int'(dut.state), int'(S_FILL));

        // Climb to 150, then exercise the flow comparison and reset mid-fill.
        run(35 * TD);
        check("level_144", int'(level), 144);
        set_in(0, 1, 1, 0, 0, 0);
        run(6 * TD);
        check("level_150", int'(level), 150);
        check("state_fill_net1", int'(dut.state), int'(S_FILL));
        set_in(0, 1, 1, 1, 0, 0);
        run(TD);
        check("balanced_level", int'(level), 150);
        check("state_idle_balanced", int'(dut.state), int'(S_IDLE));
        set_in(0, 1, 0, 0, 1, 0);
        run(1);
        check("state_drain", int'(dut.state), int'(S_DRAIN));
        set_in(0, 1, 0, 0, 0, 0);
        run(1);
        check("state_fill_again", int'(dut.state), int'(S_FILL));
        set_in(1, 1, 0, 0, 0, 0);
        run(1);
        check("rst_mid_level", int'(level), 0);
        check("rst_mid_L", int'(L), 1);
        check("rst_mid_E", int'(E), 0);
        check("rst_mid_state", int'(dut.state), int'(S_IDLE));

        // Randomised segments against the model.
        set_in(0, 0, 0, 0, 0, 0);
        for (int seg = 0; seg < 400; seg++) begin
            set_in($urandom_range(0, 99) < 2,
                   $urandom_range(0, 99) < 60,
                   $urandom_range(0, 99) < 25,
                   $urandom_range(0, 99) < 25,
                   $urandom_range(0, 99) < 20,
                   $urandom_range(0, 99) < 25);
            run($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
